// File: rtl/gf_pkg.sv
// Shared types and constants for the iterative binary-field multiplier.
// Defaults describe the AES field GF(2^8) with x^8+x^4+x^3+x+1.
package gf_pkg;

    localparam int                   AES_WIDTH = 8;
    localparam logic [AES_WIDTH-1:0] AES_POLY  = 8'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } gf_state_e;

    // Ceiling log2, usable in localparam expressions on any toolchain.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/gf_xtime_step.sv
// One Horner step of a GF(2^WIDTH) multiply: y = xtime(acc) ^ (b_bit ? a : 0).
// Purely combinational; chained DIGIT times by the multiplier top.
module gf_xtime_step
    import gf_pkg::*;
#(
    parameter int               WIDTH = AES_WIDTH,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(AES_POLY)
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] a,
    input  logic             b_bit,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] acc_x2;

    always_comb begin
        // Multiply by x, folding the overflowing x^WIDTH term back in as POLY.
        acc_x2 = {acc[WIDTH-2:0], 1'b0} ^ (acc[WIDTH-1] ? POLY : '0);
        y      = acc_x2 ^ (b_bit ? a : '0);
    end

endmodule

// File: rtl/gf_mult_iter.sv
// Iterative GF(2^WIDTH) multiplier, DIGIT multiplier bits per cycle, MSB first.
// Latency is fixed at WIDTH/DIGIT cycles regardless of operand values.
module gf_mult_iter
    import gf_pkg::*;
#(
    parameter int               WIDTH = AES_WIDTH,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(AES_POLY),
    parameter int               DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
);

    localparam int               N        = WIDTH / DIGIT;
    localparam int               CNT_W    = clog2(N + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("gf_mult_iter: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    gf_state_e        state_q, state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;

    // chain[i] is the accumulator after i Horner steps within this cycle.
    logic [DIGIT:0][WIDTH-1:0] chain;

    assign chain[0] = acc_q;

    generate
        for (genvar i = 0; i < DIGIT; i++) begin : g_step
            gf_xtime_step #(
                .WIDTH (WIDTH),
                .POLY  (POLY)
            ) u_step (
                .acc   (chain[i]),
                .a     (a_q),
                .b_bit (b_q[WIDTH-1-i]),
                .y     (chain[i+1])
            );
        end
    endgenerate

    // NOTE: sequential state is assigned with non-blocking (<=) so every register
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                // Result transfer and the next accept share this edge.
                in_ready  = out_ready;
                if (out_ready) begin
                    state_d = in_valid ? BUSY : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign accept = in_valid && in_ready;

    // NOTE: the datapath registers are reset too, because out must read 0 after
    // reset and an aborted operation must leave no residue behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            a_q   <= in2;
            b_q   <= in1;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (state_q == BUSY) begin
            acc_q <= chain[DIGIT];
            b_q   <= b_q << DIGIT;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign out = acc_q;

endmodule
